// File: rtl/dma_cfg_frontend.sv
// dma_cfg_frontend: register-mapped configuration responder for the DMA engine.
// Holds the transfer descriptor (SRC/DST/NUM_BYTES/CONF), launches it to the
// backend when NEXT_ID is read, and counts completions in DONE_ID.
// Build option: define DMA_CFG_ERR_RESP_EN to answer unmapped/misaligned
// accesses and writes to read-only registers with SLVERR (2'b10); when it is
// undefined every access answers OKAY. Register contents are the same either way.
// AddrWidth must be larger than 12; only addr[11:0] is decoded.
module dma_cfg_frontend #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [AddrWidth-1:0]   aw_addr_i,
  input  logic                   aw_valid_i,
  output logic                   aw_ready_o,
  input  logic [DataWidth-1:0]   w_data_i,
  input  logic [DataWidth/8-1:0] w_strb_i,
  input  logic                   w_valid_i,
  output logic                   w_ready_o,
  output logic [1:0]             b_resp_o,
  output logic                   b_valid_o,
  input  logic                   b_ready_i,
  input  logic [AddrWidth-1:0]   ar_addr_i,
  input  logic                   ar_valid_i,
  output logic                   ar_ready_o,
  output logic [DataWidth-1:0]   r_data_o,
  output logic [1:0]             r_resp_o,
  output logic                   r_valid_o,
  input  logic                   r_ready_i,
  output logic [DataWidth-1:0]   desc_src_o,
  output logic [DataWidth-1:0]   desc_dst_o,
  output logic [DataWidth-1:0]   desc_len_o,
  output logic                   desc_decouple_o,
  output logic                   desc_deburst_o,
  output logic                   desc_valid_o,
  input  logic                   desc_ready_i,
  input  logic                   done_i
);

  // Read FSM states:
  //   state    | meaning
  //   StIdle   | waiting for a read address; ar_ready_o high
  //   StLaunch | descriptor offered to the backend, waiting for desc_ready_i
  //   StResp   | read data held on R until r_ready_i

  localparam int StrbWidth = int'(DataWidth / 8);

  localparam logic [11:0] OffSrc    = 12'h000;
  localparam logic [11:0] OffDst    = 12'h008;
  localparam logic [11:0] OffNum    = 12'h010;
  localparam logic [11:0] OffConf   = 12'h018;
  localparam logic [11:0] OffNextId = 12'h020;
  localparam logic [11:0] OffDoneId = 12'h028;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

`ifdef DMA_CFG_ERR_RESP_EN
  localparam logic ErrRespEn = 1'b1;
`else
  localparam logic ErrRespEn = 1'b0;
`endif

  localparam logic [DataWidth-1:0] One = {{(DataWidth-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLaunch = 2'd1,
    StResp   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [DataWidth-1:0] src_q, dst_q, num_q;
  logic [1:0]           conf_q;
  logic [DataWidth-1:0] next_id_q, done_id_q;

  logic                 b_valid_q;
  logic [1:0]           b_resp_q;
  logic                 r_valid_q;
  logic [DataWidth-1:0] r_data_q;
  logic [1:0]           r_resp_q;

  logic [DataWidth-1:0] desc_src_q, desc_dst_q, desc_len_q;
  logic                 desc_decouple_q, desc_deburst_q, desc_valid_q;

  logic [11:0] wr_off, rd_off;
  logic        wr_accept, ar_accept, rd_is_launch, desc_hs, r_hs;
  logic        wr_src, wr_dst, wr_num, wr_conf, wr_err;
  logic [DataWidth-1:0] rd_data;
  logic        rd_err;
  logic [DataWidth-1:0] next_id_inc;

  // Upper address bits lie outside the 4 KiB window and are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{aw_addr_i[AddrWidth-1:12], ar_addr_i[AddrWidth-1:12]};

  assign wr_off       = aw_addr_i[11:0];
  assign rd_off       = ar_addr_i[11:0];
  assign wr_accept    = aw_valid_i && w_valid_i && !b_valid_q;
  assign ar_accept    = ar_valid_i && (state_q == StIdle);
  assign rd_is_launch = (rd_off == OffNextId);
  assign desc_hs      = desc_valid_q && desc_ready_i;
  assign r_hs         = r_valid_q && r_ready_i;
  assign next_id_inc  = next_id_q + One;

  assign aw_ready_o = wr_accept;
  assign w_ready_o  = wr_accept;

  // Merge new write data into an old register value byte by byte.
  function automatic logic [DataWidth-1:0] apply_strb(
    input logic [DataWidth-1:0] old_val,
    input logic [DataWidth-1:0] new_val,
    input logic [StrbWidth-1:0] strb
  );
    logic [DataWidth-1:0] res;
    res = old_val;
    for (int i = 0; i < StrbWidth; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

  // Write address decode; only the four descriptor registers are writable.
  always_comb begin
    wr_src  = 1'b0;
    wr_dst  = 1'b0;
    wr_num  = 1'b0;
    wr_conf = 1'b0;
    wr_err  = 1'b1;
    case (wr_off)
      OffSrc:  begin wr_src  = wr_accept; wr_err = 1'b0; end
      OffDst:  begin wr_dst  = wr_accept; wr_err = 1'b0; end
      OffNum:  begin wr_num  = wr_accept; wr_err = 1'b0; end
      OffConf: begin wr_conf = wr_accept; wr_err = 1'b0; end
      default: ;
    endcase
  end

  // Read data mux for non-launching offsets; unmapped offsets read as zero.
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (rd_off)
      OffSrc:    rd_data = src_q;
      OffDst:    rd_data = dst_q;
      OffNum:    rd_data = num_q;
      OffConf:   rd_data = {{(DataWidth-2){1'b0}}, conf_q};
      OffNextId: rd_data = '0;
      OffDoneId: rd_data = done_id_q;
      default:   rd_err  = 1'b1;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Read FSM next-state logic and the address-ready output.
  always_comb begin
    state_d    = state_q;
    ar_ready_o = 1'b0;
    case (state_q)
      StIdle: begin
        ar_ready_o = 1'b1;
        if (ar_valid_i) state_d = rd_is_launch ? StLaunch : StResp;
      end
      StLaunch: if (desc_hs) state_d = StResp;
      StResp:   if (r_hs)    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Configuration registers, updated on the write-accept edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      src_q  <= '0;
      dst_q  <= '0;
      num_q  <= '0;
      conf_q <= '0;
    end else begin
      if (wr_src)  src_q <= apply_strb(src_q, w_data_i, w_strb_i);
      if (wr_dst)  dst_q <= apply_strb(dst_q, w_data_i, w_strb_i);
      if (wr_num)  num_q <= apply_strb(num_q, w_data_i, w_strb_i);
      if (wr_conf && w_strb_i[0]) conf_q <= w_data_i[1:0];
    end
  end

  // Write response: one outstanding write, held until b_ready_i.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      b_valid_q <= 1'b0;
      b_resp_q  <= RespOkay;
    end else if (wr_accept) begin
      b_valid_q <= 1'b1;
      b_resp_q  <= (ErrRespEn && wr_err) ? RespSlvErr : RespOkay;
    end else if (b_valid_q && b_ready_i) begin
      b_valid_q <= 1'b0;
    end
  end

  // Read response and launch ID; data is captured on the AR-accept edge,
  // or on the descriptor handshake for a launch.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= RespOkay;
      next_id_q <= '0;
    end else if (ar_accept && !rd_is_launch) begin
      r_valid_q <= 1'b1;
      r_data_q  <= rd_data;
      r_resp_q  <= (ErrRespEn && rd_err) ? RespSlvErr : RespOkay;
    end else if (desc_hs) begin
      r_valid_q <= 1'b1;
      r_data_q  <= next_id_inc;
      r_resp_q  <= RespOkay;
      next_id_q <= next_id_inc;
    end else if (r_hs) begin
      r_valid_q <= 1'b0;
    end
  end

  // Descriptor outputs are snapshotted on entry to launch so later writes
  // cannot disturb a descriptor the backend has not yet taken.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      desc_src_q      <= '0;
      desc_dst_q      <= '0;
      desc_len_q      <= '0;
      desc_decouple_q <= 1'b0;
      desc_deburst_q  <= 1'b0;
      desc_valid_q    <= 1'b0;
    end else if (ar_accept && rd_is_launch) begin
      desc_src_q      <= src_q;
      desc_dst_q      <= dst_q;
      desc_len_q      <= num_q;
      desc_decouple_q <= conf_q[0];
      desc_deburst_q  <= conf_q[1];
      desc_valid_q    <= 1'b1;
    end else if (desc_hs) begin
      desc_valid_q    <= 1'b0;
    end
  end

  // Completion counter; a pulse coincident with a DONE_ID read lands after the sample.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)     done_id_q <= '0;
    else if (done_i) done_id_q <= done_id_q + One;
  end

  assign b_valid_o       = b_valid_q;
  assign b_resp_o        = b_resp_q;
  assign r_valid_o       = r_valid_q;
  assign r_data_o        = r_data_q;
  assign r_resp_o        = r_resp_q;
  assign desc_src_o      = desc_src_q;
  assign desc_dst_o      = desc_dst_q;
  assign desc_len_o      = desc_len_q;
  assign desc_decouple_o = desc_decouple_q;
  assign desc_deburst_o  = desc_deburst_q;
  assign desc_valid_o    = desc_valid_q;

endmodule

// File: tb/tb_dma_cfg_frontend.sv
// Testbench for dma_cfg_frontend: directed accesses against a register-map
// model, with a per-cycle compare process and literal checks of key results.
`timescale 1ns/1ps
module tb_dma_cfg_frontend;

  localparam int AW = 64;
  localparam int DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_ni;
  logic [AW-1:0] aw_addr_i, ar_addr_i;
  logic          aw_valid_i, w_valid_i, b_ready_i, ar_valid_i, r_ready_i;
  logic [DW-1:0] w_data_i;
  logic [7:0]    w_strb_i;
  logic          desc_ready_i, done_i;
  logic          aw_ready_o, w_ready_o, b_valid_o, ar_ready_o, r_valid_o;
  logic [1:0]    b_resp_o, r_resp_o;
  logic [DW-1:0] r_data_o, desc_src_o, desc_dst_o, desc_len_o;
  logic          desc_decouple_o, desc_deburst_o, desc_valid_o;

  dma_cfg_frontend #(.AddrWidth(AW), .DataWidth(DW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .aw_addr_i(aw_addr_i), .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
    .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
    .b_resp_o(b_resp_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
    .ar_addr_i(ar_addr_i), .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
    .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
    .desc_src_o(desc_src_o), .desc_dst_o(desc_dst_o), .desc_len_o(desc_len_o),
    .desc_decouple_o(desc_decouple_o), .desc_deburst_o(desc_deburst_o),
    .desc_valid_o(desc_valid_o), .desc_ready_i(desc_ready_i), .done_i(done_i)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: handshake did not occur within budget at %0t", name, $time);
  endtask

  // ---------------- register-map model ----------------
  logic [63:0] m_reg [4];   // SRC, DST, NUM_BYTES, CONF
  logic [63:0] m_next, m_done;
  logic [1:0]  exp_b_resp, exp_r_resp;
  logic [63:0] exp_r_data, exp_src, exp_dst, exp_len;
  logic        exp_dec, exp_deb;

  function automatic logic [1:0] err_resp(input bit err);
`ifdef DMA_CFG_ERR_RESP_EN
    return err ? 2'b10 : 2'b00;
`else
    return 2'b00;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = '0;
    m_next = '0;
    m_done = '0;
  endtask

  task automatic model_write(input logic [11:0] off, input logic [63:0] data, input logic [7:0] strb);
    logic [63:0] mask;
    bit rw;
    rw = (off == 12'h000) || (off == 12'h008) || (off == 12'h010) || (off == 12'h018);
    mask = '0;
    for (int b = 0; b < 8; b++) if (strb[b]) mask[b*8 +: 8] = 8'hFF;
    if (rw) begin
      m_reg[off[4:3]] = (m_reg[off[4:3]] & ~mask) | (data & mask);
      if (off == 12'h018) m_reg[3] = m_reg[3] & 64'h3;
    end
    exp_b_resp = err_resp(!rw);
  endtask

  task automatic model_read(input logic [11:0] off, output logic [63:0] d, output logic [1:0] resp);
    bit mapped;
    mapped = 1'b1;
    case (off)
      12'h000: d = m_reg[0];
      12'h008: d = m_reg[1];
      12'h010: d = m_reg[2];
      12'h018: d = m_reg[3];
      12'h028: d = m_done;
      default: begin d = '0; mapped = 1'b0; end
    endcase
    resp = err_resp(!mapped);
  endtask

  // ---------------- per-cycle compare ----------------
  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en && rst_ni) begin
      check("aw_ready", aw_ready_o, aw_valid_i && w_valid_i && !b_valid_o);
      check("w_ready",  w_ready_o,  aw_valid_i && w_valid_i && !b_valid_o);
      if (b_valid_o) check("b_resp", b_resp_o, exp_b_resp);
      if (r_valid_o) begin
        check("r_data", r_data_o, exp_r_data);
        check("r_resp", r_resp_o, exp_r_resp);
      end
      if (desc_valid_o) begin
        check("desc_src", desc_src_o, exp_src);
        check("desc_dst", desc_dst_o, exp_dst);
        check("desc_len", desc_len_o, exp_len);
        check("desc_decouple", desc_decouple_o, exp_dec);
        check("desc_deburst", desc_deburst_o, exp_deb);
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic do_write(input logic [11:0] off, input logic [63:0] data,
                          input logic [7:0] strb, input int b_hold);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    aw_addr_i = {52'h0, off};
    w_data_i = data;
    w_strb_i = strb;
    aw_valid_i = 1'b1;
    w_valid_i = 1'b1;
    b_ready_i = (b_hold == 0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (aw_ready_o) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("aw_accept");
    model_write(off, data, strb);
    @(posedge clk); #1;
    aw_valid_i = 1'b0;
    w_valid_i = 1'b0;
    @(negedge clk);
    check("b_latency", b_valid_o, 1'b1);
    for (int i = 0; i < b_hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("b_hold", b_valid_o, 1'b1);
    end
    if (b_hold > 0) begin
      @(posedge clk); #1;
      b_ready_i = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    b_ready_i = 1'b0;
    @(negedge clk);
    check("b_release", b_valid_o, 1'b0);
  endtask

  task automatic snapshot_desc();
    exp_src = m_reg[0];
    exp_dst = m_reg[1];
    exp_len = m_reg[2];
    exp_dec = m_reg[3][0];
    exp_deb = m_reg[3][1];
  endtask

  task automatic do_read(input logic [11:0] off, input int desc_wait, input int r_wait,
                         input bit with_done, output logic [63:0] got);
    bit ok, launch;
    logic [63:0] rd;
    logic [1:0]  rr;
    ok = 1'b0;
    got = '0;
    launch = (off == 12'h020);
    if (launch) begin
      snapshot_desc();
      m_next = m_next + 64'd1;
      exp_r_data = m_next;
      exp_r_resp = 2'b00;
    end else begin
      model_read(off, rd, rr);
      exp_r_data = rd;
      exp_r_resp = rr;
    end
    @(posedge clk); #1;
    ar_addr_i = {52'h0, off};
    ar_valid_i = 1'b1;
    r_ready_i = (r_wait == 0);
    desc_ready_i = 1'b0;
    if (with_done) done_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ar_ready_o) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("ar_accept");
    @(posedge clk); #1;
    ar_valid_i = 1'b0;
    if (with_done) begin
      done_i = 1'b0;
      m_done = m_done + 64'd1;
    end
    if (launch) begin
      for (int i = 0; i < desc_wait; i++) begin
        @(negedge clk);
        check("desc_valid_wait", desc_valid_o, 1'b1);
        check("ar_ready_launch", ar_ready_o, 1'b0);
        check("r_valid_launch", r_valid_o, 1'b0);
        @(posedge clk); #1;
      end
      desc_ready_i = 1'b1;
      @(negedge clk);
      check("desc_valid_hs", desc_valid_o, 1'b1);
      @(posedge clk); #1;
      desc_ready_i = 1'b0;
    end
    @(negedge clk);
    check("r_latency", r_valid_o, 1'b1);
    if (launch) check("desc_drop", desc_valid_o, 1'b0);
    got = r_data_o;
    for (int i = 0; i < r_wait; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("r_hold", r_valid_o, 1'b1);
    end
    if (r_wait > 0) begin
      @(posedge clk); #1;
      r_ready_i = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    r_ready_i = 1'b0;
    @(negedge clk);
    check("r_release", r_valid_o, 1'b0);
    check("ar_ready_idle", ar_ready_o, 1'b1);
  endtask

  task automatic pulse_done();
    @(posedge clk); #1;
    done_i = 1'b1;
    @(posedge clk); #1;
    done_i = 1'b0;
    m_done = m_done + 64'd1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_b_valid"}, b_valid_o, 1'b0);
    check({tag, "_b_resp"}, b_resp_o, 2'b00);
    check({tag, "_r_valid"}, r_valid_o, 1'b0);
    check({tag, "_r_data"}, r_data_o, 64'h0);
    check({tag, "_r_resp"}, r_resp_o, 2'b00);
    check({tag, "_desc_valid"}, desc_valid_o, 1'b0);
    check({tag, "_desc_src"}, desc_src_o, 64'h0);
    check({tag, "_desc_dst"}, desc_dst_o, 64'h0);
    check({tag, "_desc_len"}, desc_len_o, 64'h0);
    check({tag, "_desc_flags"}, {desc_decouple_o, desc_deburst_o}, 2'b00);
    check({tag, "_aw_ready"}, aw_ready_o, 1'b0);
    check({tag, "_ar_ready"}, ar_ready_o, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  logic [63:0] got;
  logic [63:0] got2;

  initial begin
    rst_ni = 1'b0;
    aw_addr_i = '0; ar_addr_i = '0; w_data_i = '0; w_strb_i = '0;
    aw_valid_i = 1'b0; w_valid_i = 1'b0; b_ready_i = 1'b0;
    ar_valid_i = 1'b0; r_ready_i = 1'b0; desc_ready_i = 1'b0; done_i = 1'b0;
    exp_b_resp = '0; exp_r_resp = '0; exp_r_data = '0;
    exp_src = '0; exp_dst = '0; exp_len = '0; exp_dec = 1'b0; exp_deb = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");
    chk_en = 1'b1;

    // Program the descriptor and read it back.
    do_write(12'h000, 64'h8000_1000, 8'hFF, 0);
    do_write(12'h008, 64'h8000_2000, 8'hFF, 2);
    do_write(12'h010, 64'h40, 8'hFF, 0);
    do_write(12'h018, 64'h3, 8'hFF, 0);
    do_read(12'h000, 0, 0, 1'b0, got); check("rb_src", got, 64'h8000_1000);
    do_read(12'h008, 0, 0, 1'b0, got); check("rb_dst", got, 64'h8000_2000);
    do_read(12'h010, 0, 0, 1'b0, got); check("rb_num", got, 64'h40);
    do_read(12'h018, 0, 2, 1'b0, got); check("rb_conf", got, 64'h3);

    // Byte strobes and CONF masking.
    do_write(12'h000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0);
    do_write(12'h000, 64'h0, 8'h0F, 0);
    do_read(12'h000, 0, 0, 1'b0, got); check("strb_src", got, 64'hFFFF_FFFF_0000_0000);
    do_write(12'h018, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0);
    do_read(12'h018, 0, 0, 1'b0, got); check("conf_mask", got, 64'h2);
    do_write(12'h018, 64'h3, 8'h01, 0);
    do_write(12'h000, 64'h8000_1000, 8'hFF, 0);

    // Launch with a slow backend; a write landing during launch must not
    // alter the offered descriptor.
    fork
      do_read(12'h020, 5, 2, 1'b0, got);
      begin
        repeat (2) @(posedge clk);
        do_write(12'h000, 64'hDEAD_0000, 8'hFF, 0);
      end
    join
    check("launch1_id", got, 64'h1);
    do_read(12'h020, 1, 0, 1'b0, got); check("launch2_id", got, 64'h2);

    // Completion counting, including a pulse coincident with the AR.
    pulse_done(); pulse_done(); pulse_done();
    do_read(12'h028, 0, 0, 1'b0, got); check("done_3", got, 64'h3);
    do_read(12'h028, 0, 0, 1'b1, got); check("done_coincident", got, 64'h3);
    do_read(12'h028, 0, 0, 1'b0, got); check("done_4", got, 64'h4);

    // Read and write of the same register on the same edge returns the old value.
    fork
      do_read(12'h008, 0, 0, 1'b0, got);
      do_write(12'h008, 64'h1234_5678, 8'hFF, 0);
    join
    check("rw_same_edge", got, 64'h8000_2000);
    do_read(12'h008, 0, 0, 1'b0, got); check("rw_after", got, 64'h1234_5678);

    // Unmapped, misaligned and read-only accesses.
    do_write(12'h030, 64'hAAAA_5555, 8'hFF, 0);
    do_write(12'h001, 64'hBBBB_0000, 8'hFF, 0);
    do_write(12'h020, 64'h99, 8'hFF, 0);
    do_write(12'h028, 64'h77, 8'hFF, 1);
    do_read(12'h004, 0, 0, 1'b0, got); check("unmapped_data", got, 64'h0);
`ifdef DMA_CFG_ERR_RESP_EN
    check("unmapped_resp_lit", exp_r_resp, 2'b10);
`else
    check("unmapped_resp_lit", exp_r_resp, 2'b00);
`endif
    do_read(12'h000, 0, 0, 1'b0, got);  check("err_src_kept", got, 64'hDEAD_0000);
    do_read(12'h028, 0, 0, 1'b0, got2); check("err_done_kept", got2, 64'h4);
    do_read(12'h020, 0, 0, 1'b0, got);  check("err_next_kept", got, 64'h3);

    // Reset while a descriptor is pending.
    snapshot_desc();
    @(posedge clk); #1;
    ar_addr_i = 64'h20;
    ar_valid_i = 1'b1;
    desc_ready_i = 1'b0;
    @(posedge clk); #1;
    ar_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("pre_reset_desc_valid", desc_valid_o, 1'b1);
    @(posedge clk); #1;
    rst_ni = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    do_read(12'h020, 0, 0, 1'b0, got); check("post_reset_id", got, 64'h1);
    do_read(12'h000, 0, 0, 1'b0, got); check("post_reset_src", got, 64'h0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d n_err=%0d", n_cmp, n_err);
    $fatal(1);
  end

endmodule
